disp_rdarb: RTL and testbench

DISP_RDARB -- requirements
Module: disp_rdarb

---
 rtl/disp_pkg.sv | 26 ++
 rtl/disp_rdarb_if.sv | 31 +++
 rtl/disp_rdarb_sel.sv | 58 +++++
 rtl/disp_rdarb.sv | 110 +++++++++++
 tb/tb_disp_rdarb.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_pkg : shared widths, FSM encoding and grant codes for disp_rdarb
// Rev 1.0
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 64;
    localparam int LEN_W          = 8;
    localparam int RESP_W         = 2;
    localparam int STARVE_W       = 3;
    localparam int STARVE_LIM_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/disp_rdarb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_rdarb_if : one read-address / read-data channel pair
// Rev 1.0
// ---------------------------------------------------------------------------
interface disp_rdarb_if;
    import disp_pkg::*;

    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [RESP_W-1:0] RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    // master issues addresses and accepts data
    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );

endinterface
`default_nettype wire

// File: rtl/disp_rdarb_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_rdarb_sel : M0-priority grant decision with M1 anti-starvation counter
// Rev 1.0
// ---------------------------------------------------------------------------
module disp_rdarb_sel
    import disp_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic       ACLK,
    input  logic       ARST,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_take,
    output logic [1:0] o_win
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    always_comb begin
        o_win = GNT_NONE;
        if (i_req1 && (!i_req0 || (starve_q >= LIM))) begin
            o_win = GNT_M1;
        end else if (i_req0) begin
            o_win = GNT_M0;
        end
    end

    // Counter only moves on a taken grant; it measures M1's lost arbitrations
    always_comb begin
        starve_d = starve_q;
        if (i_take) begin
            if (o_win == GNT_M1) begin
                starve_d = '0;
            end else if (o_win == GNT_M0) begin
                if (!i_req1) begin
                    starve_d = '0;
                end else if (starve_q < LIM) begin
                    starve_d = starve_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/disp_rdarb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_rdarb : two-requester read arbiter onto one memory port, one burst
//              outstanding at a time
// Rev 1.0
// ---------------------------------------------------------------------------
module disp_rdarb
    import disp_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic             ACLK,
    input  logic             ARST,
    disp_rdarb_if.slave      M0,
    disp_rdarb_if.slave      M1,
    disp_rdarb_if.master     MEM,
    output logic [1:0]       GNT
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] gnt_q;
    logic [1:0] gnt_d;

    logic [1:0] w_win;
    logic       w_take;
    logic       w_addr_ph;
    logic       w_data_ph;
    logic       w_rready;

    assign w_take    = (state_q == ST_IDLE) && (M0.ARVALID || M1.ARVALID);
    assign w_addr_ph = (state_q == ST_ADDR);
    assign w_data_ph = (state_q == ST_DATA);

    disp_rdarb_sel #(
        .STARVE_LIM (STARVE_LIM)
    ) u_sel (
        .ACLK   (ACLK),
        .ARST   (ARST),
        .i_req0 (M0.ARVALID),
        .i_req1 (M1.ARVALID),
        .i_take (w_take),
        .o_win  (w_win)
    );

    always_ff @(posedge ACLK) begin
        if (!ARST) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // Address phase completes on the registered grant even if the requester
    // withdraws its ARVALID
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_take) begin
                    state_d = ST_ADDR;
                    gnt_d   = w_win;
                end
            end
            ST_ADDR: begin
                if (MEM.ARREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (MEM.RVALID && w_rready && MEM.RLAST) begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    assign MEM.ARVALID = w_addr_ph;
    assign MEM.ARADDR  = !w_addr_ph ? '0 : (gnt_q[1] ? M1.ARADDR : M0.ARADDR);
    assign MEM.ARLEN   = !w_addr_ph ? '0 : (gnt_q[1] ? M1.ARLEN  : M0.ARLEN);

    assign M0.ARREADY  = w_addr_ph && gnt_q[0] && MEM.ARREADY;
    assign M1.ARREADY  = w_addr_ph && gnt_q[1] && MEM.ARREADY;

    assign w_rready    = w_data_ph && ((gnt_q[0] && M0.RREADY) || (gnt_q[1] && M1.RREADY));
    assign MEM.RREADY  = w_rready;

    assign M0.RVALID   = w_data_ph && gnt_q[0] && MEM.RVALID;
    assign M1.RVALID   = w_data_ph && gnt_q[1] && MEM.RVALID;
    assign M0.RLAST    = w_data_ph && gnt_q[0] && MEM.RLAST;
    assign M1.RLAST    = w_data_ph && gnt_q[1] && MEM.RLAST;

    // read data is shared by both requesters with no pipeline stage
    assign M0.RDATA    = MEM.RDATA;
    assign M1.RDATA    = MEM.RDATA;
    assign M0.RRESP    = MEM.RRESP;
    assign M1.RRESP    = MEM.RRESP;

    assign GNT         = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_rdarb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_disp_rdarb : self-checking bench for disp_rdarb with memory slave model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_disp_rdarb;
    import disp_pkg::*;

    localparam int LIM = 4;

    logic       ACLK = 1'b0;
    logic       ARST = 1'b0;
    logic [1:0] GNT;

    disp_rdarb_if m0_if ();
    disp_rdarb_if m1_if ();
    disp_rdarb_if mem_if ();

    disp_rdarb #(.STARVE_LIM(LIM)) dut (
        .ACLK (ACLK),
        .ARST (ARST),
        .M0   (m0_if),
        .M1   (m1_if),
        .MEM  (mem_if),
        .GNT  (GNT)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] own2gnt(input int o);
        return (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
    endfunction

    // ---------------- memory slave model ----------------
    int          ar_mode = 0;   // 0 ready, 1 random, 2 held low
    bit          rv_rand = 0;
    bit          stray   = 0;
    bit          m_busy  = 0;
    logic [31:0] m_addr  = '0;
    int          m_len   = 0;
    int          m_beat  = 0;

    initial begin
        mem_if.ARREADY = 1'b0;
        mem_if.RVALID  = 1'b0;
        mem_if.RDATA   = '0;
        mem_if.RRESP   = '0;
        mem_if.RLAST   = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARST) begin
                m_busy = 0;
            end else begin
                if (m_busy && mem_if.RVALID && mem_if.RREADY) begin
                    if (mem_if.RLAST) m_busy = 0;
                    else m_beat++;
                end
                if (mem_if.ARVALID && mem_if.ARREADY) begin
                    m_busy = 1;
                    m_addr = mem_if.ARADDR;
                    m_len  = int'(mem_if.ARLEN);
                    m_beat = 0;
                end
            end
            @(posedge ACLK);
            #1;
            mem_if.ARREADY = !m_busy && ((ar_mode == 0) || ((ar_mode == 1) && ($urandom_range(0, 2) != 0)));
            if (m_busy) begin
                mem_if.RVALID = rv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                mem_if.RDATA  = {m_addr, 32'(m_beat)};
                mem_if.RRESP  = 2'(m_beat);
                mem_if.RLAST  = (m_beat == m_len);
            end else if (stray && ($urandom_range(0, 1) == 1)) begin
                mem_if.RVALID = 1'b1;
                mem_if.RDATA  = {$urandom, $urandom};
                mem_if.RRESP  = 2'b11;
                mem_if.RLAST  = 1'($urandom_range(0, 1));
            end else begin
                mem_if.RVALID = 1'b0;
                mem_if.RDATA  = '0;
                mem_if.RRESP  = '0;
                mem_if.RLAST  = 1'b0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    int          own    = -1;   // current burst owner, -1 when port is free
    bit          dph    = 0;    // address accepted, data pending
    int          starve = 0;
    logic [31:0] e_addr = '0;
    int          e_len  = 0;
    int          e_beat = 0;
    int          beats[2];
    int          lasts[2];

    initial begin
        logic v0, v1, rr, exp_rr, o_rd, o_rl;
        logic [31:0] o_addr;
        logic [7:0]  o_len;
        logic [63:0] o_data;
        beats = '{0, 0};
        lasts = '{0, 0};
        forever begin
            @(negedge ACLK);
            v0     = m0_if.ARVALID;
            v1     = m1_if.ARVALID;
            rr     = (own == 1) ? m1_if.RREADY : m0_if.RREADY;
            exp_rr = (own >= 0) && dph && rr;
            o_addr = (own == 1) ? m1_if.ARADDR : m0_if.ARADDR;
            o_len  = (own == 1) ? m1_if.ARLEN  : m0_if.ARLEN;
            o_data = (own == 1) ? m1_if.RDATA  : m0_if.RDATA;
            o_rl   = (own == 1) ? m1_if.RLAST  : m0_if.RLAST;
            o_rd   = (own >= 0) && dph && mem_if.RVALID;

            chk("gnt", GNT, own2gnt(own));
            chk("arvalid", mem_if.ARVALID, (own >= 0) && !dph);
            chk("araddr", mem_if.ARADDR, ((own >= 0) && !dph) ? o_addr : 32'h0);
            chk("arlen", mem_if.ARLEN, ((own >= 0) && !dph) ? o_len : 8'h0);
            chk("m0_arready", m0_if.ARREADY, (own == 0) && !dph && mem_if.ARREADY);
            chk("m1_arready", m1_if.ARREADY, (own == 1) && !dph && mem_if.ARREADY);
            chk("rready", mem_if.RREADY, exp_rr);
            chk("m0_rvalid", m0_if.RVALID, (own == 0) && o_rd);
            chk("m1_rvalid", m1_if.RVALID, (own == 1) && o_rd);
            chk("m0_rdata", m0_if.RDATA, mem_if.RDATA);
            chk("m1_rdata", m1_if.RDATA, mem_if.RDATA);
            chk("m1_rresp", m1_if.RRESP, mem_if.RRESP);
            if (own >= 0 && dph) chk("rlast_route", o_rl, mem_if.RLAST);

            if (exp_rr && mem_if.RVALID) begin
                chk("beat_data", o_data, {e_addr, 32'(e_beat)});
                chk("beat_last", o_rl, e_beat == e_len);
                beats[own]++;
                if (o_rl) lasts[own]++;
                e_beat++;
            end

            if (!ARST) begin
                own    = -1;
                dph    = 0;
                starve = 0;
            end else if (own < 0) begin
                if (v0 || v1) begin
                    if (v1 && (!v0 || starve == LIM)) begin
                        own    = 1;
                        starve = 0;
                    end else begin
                        own    = 0;
                        starve = v1 ? ((starve < LIM) ? starve + 1 : LIM) : 0;
                    end
                    dph    = 0;
                    e_addr = (own == 1) ? m1_if.ARADDR : m0_if.ARADDR;
                    e_len  = int'((own == 1) ? m1_if.ARLEN : m0_if.ARLEN);
                    e_beat = 0;
                end
            end else if (!dph) begin
                if (mem_if.ARREADY) dph = 1;
            end else if (exp_rr && mem_if.RVALID && mem_if.RLAST) begin
                own = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic req(input int x, input logic [31:0] a, input logic [7:0] l);
        if (x == 0) begin
            m0_if.ARVALID = 1'b1; m0_if.ARADDR = a; m0_if.ARLEN = l;
        end else begin
            m1_if.ARVALID = 1'b1; m1_if.ARADDR = a; m1_if.ARLEN = l;
        end
    endtask

    task automatic set_rr(input int x, input logic v);
        if (x == 0) m0_if.RREADY = v;
        else        m1_if.RREADY = v;
    endtask

    task automatic wait_ar(input int x, input string name);
        int n = 0;
        bit got = 0;
        while (!got && n < 50) begin
            @(negedge ACLK);
            got = (x == 0) ? (m0_if.ARVALID && m0_if.ARREADY) : (m1_if.ARVALID && m1_if.ARREADY);
            n++;
        end
        chk({name, "_ar_hs"}, got, 1);
        tick();
        if (x == 0) m0_if.ARVALID = 1'b0;
        else        m1_if.ARVALID = 1'b0;
    endtask

    task automatic wait_last(input int x, input string name, input bit toggle);
        int l0 = lasts[x];
        int n  = 0;
        while (lasts[x] == l0 && n < 200) begin
            if (toggle) set_rr(x, (x == 0) ? ~m0_if.RREADY : ~m1_if.RREADY);
            tick();
            n++;
        end
        chk({name, "_done"}, lasts[x] != l0, 1);
    endtask

    typedef struct {
        bit         v0;
        bit         v1;
        logic [1:0] gnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int b0, b1, l0, n;
        bit pend0, pend1, hs;
        logic [1:0] g;

        tbl = '{
            '{1'b1, 1'b0, 2'b01}, '{1'b0, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b01},
            '{1'b0, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b01},
            '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b10},
            '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b0, 2'b01}, '{1'b1, 1'b1, 2'b01}
        };

        m0_if.ARVALID = 0; m0_if.ARADDR = '0; m0_if.ARLEN = '0; m0_if.RREADY = 0;
        m1_if.ARVALID = 0; m1_if.ARADDR = '0; m1_if.ARLEN = '0; m1_if.RREADY = 0;
        ARST = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", GNT, 2'b00);
        chk("rst_arvalid", mem_if.ARVALID, 0);
        chk("rst_rready", mem_if.RREADY, 0);
        ARST = 1'b1;
        tick();

        // grant order table: single-beat bursts
        m0_if.RREADY = 1; m1_if.RREADY = 1;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].v0) req(0, 32'(32'h1000_0000 + i * 16), 8'd0);
            if (tbl[i].v1) req(1, 32'(32'h1800_0000 + i * 16), 8'd0);
            hs = 0; n = 0; g = '0;
            while (!hs && n < 20) begin
                @(negedge ACLK);
                hs = (m0_if.ARVALID && m0_if.ARREADY) || (m1_if.ARVALID && m1_if.ARREADY);
                g  = GNT;
                n++;
            end
            chk($sformatf("tbl%0d_hs", i), hs, 1);
            chk($sformatf("tbl%0d_gnt", i), g, tbl[i].gnt);
            tick();
            m0_if.ARVALID = 0; m1_if.ARVALID = 0;
            wait_last(g[1] ? 1 : 0, $sformatf("tbl%0d", i), 0);
        end

        // single M0 16-beat burst
        b0 = beats[0]; b1 = beats[1];
        req(0, 32'h2000_0000, 8'd15);
        wait_ar(0, "r29");
        wait_last(0, "r29", 0);
        chk("r29_m0_beats", beats[0] - b0, 16);
        chk("r29_m1_beats", beats[1] - b1, 0);
        @(negedge ACLK);
        chk("r29_idle_gnt", GNT, 2'b00);
        tick();

        // address phase stalled for 5 cycles
        ar_mode = 2;
        req(0, 32'h3000_0040, 8'd3);
        @(negedge ACLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk($sformatf("r32_arvalid%0d", k), mem_if.ARVALID, 1);
            chk($sformatf("r32_araddr%0d", k), mem_if.ARADDR, 32'h3000_0040);
            chk($sformatf("r32_arready%0d", k), m0_if.ARREADY, 0);
        end
        ar_mode = 0;
        wait_ar(0, "r32");
        wait_last(0, "r32", 0);

        // M1 with toggling RREADY
        req(1, 32'h4000_0000, 8'd15);
        wait_ar(1, "r33");
        b1 = beats[1]; l0 = lasts[1];
        wait_last(1, "r33", 1);
        chk("r33_beats", beats[1] - b1, 16);
        chk("r33_lasts", lasts[1] - l0, 1);
        m1_if.RREADY = 1;

        // reset mid-burst, then a fresh M1 burst
        req(0, 32'h5000_0000, 8'd15);
        wait_ar(0, "r34");
        b0 = beats[0]; n = 0;
        while (beats[0] - b0 < 7 && n < 100) begin tick(); n++; end
        chk("r34_reach7", beats[0] - b0, 7);
        ARST = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("r34_gnt", GNT, 2'b00);
        chk("r34_arvalid", mem_if.ARVALID, 0);
        chk("r34_rready", mem_if.RREADY, 0);
        chk("r34_m0_rvalid", m0_if.RVALID, 0);
        chk("r34_m0_rdata", m0_if.RDATA, 64'h0);
        tick();
        ARST = 1'b1;
        b1 = beats[1];
        req(1, 32'h6000_0100, 8'd3);
        wait_ar(1, "r34b");
        wait_last(1, "r34b", 0);
        chk("r34b_beats", beats[1] - b1, 4);

        // randomized traffic against the reference model
        rv_rand = 1; stray = 1; pend0 = 0; pend1 = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge ACLK);
            if (m0_if.ARVALID && m0_if.ARREADY) pend0 = 0;
            if (m1_if.ARVALID && m1_if.ARREADY) pend1 = 0;
            ar_mode = $urandom_range(0, 1);
            @(posedge ACLK);
            #1;
            if (c % 500 == 250) begin
                ARST = 1'b0; pend0 = 0; pend1 = 0;
            end else begin
                ARST = 1'b1;
            end
            if (!pend0 && $urandom_range(0, 3) == 0) begin
                pend0 = 1; m0_if.ARADDR = $urandom; m0_if.ARLEN = 8'($urandom_range(0, 7));
            end
            if (!pend1 && $urandom_range(0, 3) == 0) begin
                pend1 = 1; m1_if.ARADDR = $urandom; m1_if.ARLEN = 8'($urandom_range(0, 7));
            end
            m0_if.ARVALID = pend0;
            m1_if.ARVALID = pend1;
            m0_if.RREADY  = ($urandom_range(0, 3) != 0);
            m1_if.RREADY  = ($urandom_range(0, 3) != 0);
        end

        m0_if.ARVALID = 0; m1_if.ARVALID = 0;
        m0_if.RREADY = 1; m1_if.RREADY = 1;
        ARST = 1'b1; rv_rand = 0; stray = 0; ar_mode = 0;
        repeat (40) tick();
        @(negedge ACLK);
        chk("drain_idle", GNT, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
